// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with 50% duty for odd and even ratios.
// Divisor changes and stop requests take effect only at output-period boundaries.
module clk_div_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic [WIDTH-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] last_hi;
  logic             pos_q, pos_d, neg_q;
  logic             stop_q, stop_d;
  logic             err_q, err_d;
  logic             running, xfer, cfg_ok, wrap, halt;

  assign running   = (state_q != IDLE);
  assign cfg_ready = (state_q != PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_div >= WIDTH'(2));
  assign wrap      = running && (cnt_q == div_q - WIDTH'(1));
  // A stop request seen at any point in the period is honoured at its wrap.
  assign halt      = !enable || stop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    stop_d  = stop_q;
    err_d   = xfer && !cfg_ok;
    case (state_q)
      RUN, PEND: begin
        if (!enable) stop_d = 1'b1;
        if (state_q == RUN && xfer && cfg_ok) begin
          pend_d  = cfg_div;
          state_d = PEND;
        end
        if (wrap) begin
          cnt_d = '0;
          if (state_q == PEND) div_d = pend_q;
          if (halt) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            if (state_q == RUN && xfer && cfg_ok) div_d = cfg_div;
          end else if (state_q == PEND) begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        stop_d = 1'b0;
        cnt_d  = '0;
        if (xfer && cfg_ok) div_d = cfg_div;
        if (enable) state_d = RUN;
      end
    endcase
  end

  // Last count of the high phase: floor(N/2) for odd N, N/2-1 for even N.
  assign last_hi = div_d[0] ? (div_d >> 1) : ((div_d >> 1) - WIDTH'(1));
  assign pos_d   = (state_d != IDLE) && (cnt_d <= last_hi);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      pend_q  <= '0;
      pos_q   <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
    end
  end

  // Half-cycle delayed copy; ANDed with pos_q it trims half an input period for odd N.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  assign clk_out    = div_q[0] ? (pos_q & neg_q) : pos_q;
  assign tick       = running && (cnt_q == '0);
  assign busy       = (state_q == PEND);
  assign cfg_err    = err_q;
  assign div_active = div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: duty, period, tick alignment,
// boundary-aligned divisor changes, rejection, stop and asynchronous reset.
module tb_clk_div_ctrl;

  logic       clk_in, rst, enable, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, busy, clk_out, tick;
  logic [7:0] div_active;

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .div_active (div_active),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  initial begin
    clk_in = 1'b0;
    forever #15 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample 1 ns after every clk_in edge (half-period resolution).
  task automatic sample();
    @(posedge clk_in or negedge clk_in);
    #1;
  endtask

  // Find the next clk_out rise, then measure one full period starting there.
  // Returns at the sample that shows the following rise.
  task automatic measure(output int hi_ns, output int per_ns, output int ticks,
                         output logic rise_tick, output time t_rise, output logic ok);
    logic prev, prev_tick, high_done, found;
    hi_ns = 0; per_ns = 0; ticks = 0; rise_tick = 1'b0; ok = 1'b0; found = 1'b0;
    t_rise = 0;
    prev = clk_out;
    for (int i = 0; i < 60 && !found; i++) begin
      sample();
      if (!prev && clk_out) found = 1'b1;
      prev = clk_out;
    end
    if (!found) return;
    t_rise = $time;
    rise_tick = tick;
    prev_tick = tick;
    high_done = 1'b0;
    hi_ns = 15;
    for (int i = 0; i < 60; i++) begin
      sample();
      per_ns += 15;
      if (tick && !prev_tick) ticks++;
      prev_tick = tick;
      if (!high_done) begin
        if (clk_out) hi_ns += 15;
        else high_done = 1'b1;
      end else if (clk_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cfg_write(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    @(posedge clk_in);
    #1;
    cfg_valid = 1'b0;
  endtask

  int   hi, per, tk, cnt;
  logic rt, ok;
  time  tr, t_mark;

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_div", div_active, 5);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    repeat (6) sample();
    chk("idle_clk_out", clk_out, 0);

    // N=5 run
    enable = 1'b1;
    measure(hi, per, tk, rt, tr, ok);
    chk("n5_found", ok, 1);
    chk("n5_high_ns", hi, 75);
    chk("n5_period_ns", per, 150);
    chk("n5_ticks", tk, 1);
    chk("n5_tick_at_rise", rt, 1);

    // Drop enable mid-high: the high phase must finish, then stay idle
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (clk_out) cnt++;
      else break;
    end
    chk("stop_rest_high", cnt, 4);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (clk_out || tick) cnt++;
    end
    chk("stop_idle_activity", cnt, 0);

    // Divisor 4 set in IDLE
    cfg_write(8'd4);
    chk("n4_div", div_active, 4);
    enable = 1'b1;
    measure(hi, per, tk, rt, tr, ok);
    chk("n4_found", ok, 1);
    chk("n4_high_ns", hi, 60);
    chk("n4_period_ns", per, 120);
    chk("n4_ticks", tk, 1);
    chk("n4_tick_at_rise", rt, 1);

    // Back to N=5, then offer 3 mid-period
    enable = 1'b0;
    repeat (20) sample();
    cfg_write(8'd5);
    enable = 1'b1;
    measure(hi, per, tk, rt, tr, ok);
    chk("n5b_found", ok, 1);
    t_mark = $time;
    @(posedge clk_in); #1;
    cfg_write(8'd3);
    chk("pend_busy", busy, 1);
    chk("pend_ready", cfg_ready, 0);
    chk("pend_div_old", div_active, 5);
    measure(hi, per, tk, rt, tr, ok);
    chk("n3_found", ok, 1);
    chk("n3_boundary_ns", 32'(tr - t_mark), 150);
    chk("n3_high_ns", hi, 45);
    chk("n3_period_ns", per, 90);
    chk("n3_ticks", tk, 1);
    chk("n3_busy_clear", busy, 0);
    chk("n3_ready", cfg_ready, 1);
    chk("n3_div", div_active, 3);

    // Rejected divisors
    cfg_write(8'd1);
    chk("err1_pulse", cfg_err, 1);
    @(posedge clk_in); #1;
    chk("err1_clear", cfg_err, 0);
    cfg_write(8'd0);
    chk("err0_pulse", cfg_err, 1);
    @(posedge clk_in); #1;
    chk("err0_clear", cfg_err, 0);
    chk("err_div_kept", div_active, 3);
    measure(hi, per, tk, rt, tr, ok);
    chk("err_found", ok, 1);
    chk("err_period_ns", per, 90);
    chk("err_high_ns", hi, 45);

    // Asynchronous reset during the high phase
    chk("pre_rst_high", clk_out, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_clk_out", clk_out, 0);
    chk("async_rst_div", div_active, 5);
    chk("async_rst_busy", busy, 0);
    enable = 1'b0;
    repeat (2) @(posedge clk_in);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
